// File: rtl/adder_tree_arbiter_pkg.sv
// Shared helpers for adder_tree_arbiter: width derivation and round-robin pick.
package adder_tree_arbiter_pkg;

  localparam int MAX_REQ = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  function automatic int calc_layers(input int n);
    return $clog2(n);
  endfunction

  function automatic int calc_out_w(input int dw, input int n);
    return dw + $clog2(n);
  endfunction

  function automatic int calc_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Node count of tree level l when n leaves are halved per level.
  function automatic int layer_cnt(input int n, input int l);
    return (n + (1 << l) - 1) >> l;
  endfunction

  // Walks from the farthest offset down to ptr so the closest requester wins.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [3:0] ptr, input int n);
    pick_t p;
    int    k_idx;
    p = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        k_idx = (int'(ptr) + k) % n;
        if (req[k_idx]) begin
          p.found = 1'b1;
          p.idx   = 4'(k_idx);
        end
      end
    end
    return p;
  endfunction

  function automatic logic [3:0] ptr_next(input logic [3:0] idx, input int n);
    return (int'(idx) == n - 1) ? 4'd0 : idx + 4'd1;
  endfunction

endpackage

// File: rtl/adder_tree_arbiter_adder_tree.sv
// Pipelined signed adder tree, one register per level, full-precision output.
module adder_tree
  import adder_tree_arbiter_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_INPUTS = 27,
  localparam int LAYERS     = calc_layers(NUM_INPUTS),
  localparam int OUT_W      = calc_out_w(DATA_WIDTH, NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
  output logic [OUT_W-1:0]                 o_sum
);

  genvar l, i;
  for (l = 0; l <= LAYERS; l++) begin : g_lvl
    localparam int CNT = layer_cnt(NUM_INPUTS, l);
    logic [CNT-1:0][OUT_W-1:0] s;
    if (l == 0) begin : g_leaf
      for (i = 0; i < CNT; i++) begin : g_n
        assign s[i] = OUT_W'($signed(i_data[i*DATA_WIDTH +: DATA_WIDTH]));
      end
    end else begin : g_add
      localparam int PCNT = layer_cnt(NUM_INPUTS, l - 1);
      for (i = 0; i < CNT; i++) begin : g_n
        logic signed [OUT_W-1:0] r_sum;
        if (2*i + 1 < PCNT) begin : g_pair
          always_ff @(posedge clk)
            r_sum <= $signed(g_lvl[l-1].s[2*i]) + $signed(g_lvl[l-1].s[2*i+1]);
        end else begin : g_pass
          // Odd node out: carried forward so every path has equal depth.
          always_ff @(posedge clk)
            r_sum <= $signed(g_lvl[l-1].s[2*i]);
        end
        assign s[i] = r_sum;
      end
    end
  end

  assign o_sum = g_lvl[LAYERS].s[0];

endmodule

// File: rtl/adder_tree_arbiter.sv
// Round-robin arbiter feeding one shared pipelined adder tree.
// Optional per-requester grant counters: define ADDER_TREE_ARBITER_STATS_EN.
module adder_tree_arbiter
  import adder_tree_arbiter_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_INPUTS = 27,
  parameter  int NUM_REQ    = 4,
  localparam int LAYERS     = calc_layers(NUM_INPUTS),
  localparam int OUT_W      = calc_out_w(DATA_WIDTH, NUM_INPUTS),
  localparam int ID_W       = calc_id_w(NUM_REQ)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_REQ-1:0]                       i_req,
  input  logic [NUM_REQ*NUM_INPUTS*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]                       o_grant,
  output logic [OUT_W-1:0]                         o_data,
  output logic                                     o_valid,
  output logic [ID_W-1:0]                          o_id,
  output logic                                     o_busy
`ifdef ADDER_TREE_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]                    o_grant_cnt
`endif
);

  localparam int VEC_W = NUM_INPUTS * DATA_WIDTH;

  logic [3:0]                r_ptr;
  pick_t                     w_pick;
  logic                      w_found;
  logic [VEC_W-1:0]          r_in_data;
  logic [LAYERS:0]           r_vld_pipe;
  logic [LAYERS:0][ID_W-1:0] r_id_pipe;
  logic [OUT_W-1:0]          w_sum;

  always_comb begin
    w_pick  = rr_pick(MAX_REQ'(i_req), r_ptr, NUM_REQ);
    // Gated by rst_n so nothing is granted while reset is held.
    w_found = w_pick.found & rst_n;
    o_grant = w_found ? (NUM_REQ'(1) << w_pick.idx) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_vld_pipe <= '0;
    end else begin
      if (w_found) r_ptr <= ptr_next(w_pick.idx, NUM_REQ);
      r_vld_pipe <= {r_vld_pipe[LAYERS-1:0], w_found};
    end
  end

  always_ff @(posedge clk) begin
    if (w_found) r_in_data <= i_data[w_pick.idx*VEC_W +: VEC_W];
    r_id_pipe <= {r_id_pipe[LAYERS-1:0], ID_W'(w_pick.idx)};
  end

  adder_tree #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_INPUTS (NUM_INPUTS)
  ) u_tree (
    .clk    (clk),
    .i_data (r_in_data),
    .o_sum  (w_sum)
  );

  assign o_data  = w_sum;
  assign o_valid = r_vld_pipe[LAYERS];
  assign o_id    = r_id_pipe[LAYERS];
  assign o_busy  = |r_vld_pipe;

`ifdef ADDER_TREE_ARBITER_STATS_EN
  logic [NUM_REQ-1:0][15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++)
        if (o_grant[r] && r_cnt[r] != 16'hFFFF) r_cnt[r] <= r_cnt[r] + 16'd1;
    end
  end

  assign o_grant_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Directed table-driven bench for adder_tree_arbiter (default 4 x 27 x 16-bit).
module tb_adder_tree_arbiter;

  localparam int DW  = 16;
  localparam int NI  = 27;
  localparam int NR  = 4;
  localparam int LAT = 6;
  localparam int OW  = 21;
  localparam int IW  = 2;

  logic               clk;
  logic               rst_n;
  logic [NR-1:0]      i_req;
  logic [NR*NI*DW-1:0] i_data;
  logic [NR-1:0]      o_grant;
  logic [OW-1:0]      o_data;
  logic               o_valid;
  logic [IW-1:0]      o_id;
  logic               o_busy;
`ifdef ADDER_TREE_ARBITER_STATS_EN
  logic [NR*16-1:0]   o_grant_cnt;
`endif

  adder_tree_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (i_req),
    .i_data  (i_data),
    .o_grant (o_grant),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_id    (o_id),
    .o_busy  (o_busy)
`ifdef ADDER_TREE_ARBITER_STATS_EN
    ,
    .o_grant_cnt (o_grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] exp_grant;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int exp_sum [NR];
  bit hist_v  [512];
  int hist_id [512];
  int hist_sum[512];
  int cnum;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_const(input int r, input int v);
    for (int j = 0; j < NI; j++) i_data[(r*NI+j)*DW +: DW] = 16'(v);
    exp_sum[r] = NI * v;
  endtask

  task automatic set_ramp(input int r);
    int v;
    exp_sum[r] = 0;
    for (int j = 0; j < NI; j++) begin
      v = 100*j - 1000;
      i_data[(r*NI+j)*DW +: DW] = 16'(v);
      exp_sum[r] += v;
    end
  endtask

  task automatic clr_hist();
    for (int k = 0; k < 512; k++) hist_v[k] = 1'b0;
    cnum = 0;
  endtask

  // One cycle: drive req, check grant, then check the pipeline outputs
  // against what was granted LAT cycles earlier.
  task automatic cyc(input logic [NR-1:0] req, input logic [NR-1:0] eg, input string tag);
    int  gi;
    bit  eb;
    i_req = req;
    #1;
    chk({tag, " grant"}, longint'(o_grant), longint'(eg));
    gi = 0;
    for (int k = 0; k < NR; k++) if (eg[k]) gi = k;
    hist_v[cnum]   = (eg != '0);
    hist_id[cnum]  = gi;
    hist_sum[cnum] = exp_sum[gi];
    if (cnum >= LAT) begin
      chk({tag, " valid"}, longint'(o_valid), longint'(hist_v[cnum-LAT]));
      if (hist_v[cnum-LAT]) begin
        chk({tag, " id"}, longint'(o_id), longint'(hist_id[cnum-LAT]));
        chk({tag, " data"}, longint'($signed(o_data)), longint'(hist_sum[cnum-LAT]));
      end
    end else begin
      chk({tag, " valid"}, longint'(o_valid), 0);
    end
    eb = 1'b0;
    for (int k = 1; k <= LAT; k++) if (cnum - k >= 0) eb |= hist_v[cnum-k];
    chk({tag, " busy"}, longint'(o_busy), longint'(eb));
    cnum++;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[26];

  initial begin
    tbl[0]  = '{4'b0000, 4'b0000};
    tbl[1]  = '{4'b1111, 4'b0001};
    tbl[2]  = '{4'b1111, 4'b0010};
    tbl[3]  = '{4'b1111, 4'b0100};
    tbl[4]  = '{4'b1111, 4'b1000};
    tbl[5]  = '{4'b1111, 4'b0001};
    tbl[6]  = '{4'b0100, 4'b0100};
    tbl[7]  = '{4'b1010, 4'b1000};
    tbl[8]  = '{4'b0010, 4'b0010};
    tbl[9]  = '{4'b0000, 4'b0000};
    tbl[10] = '{4'b1001, 4'b1000};
    tbl[11] = '{4'b0001, 4'b0001};
    tbl[12] = '{4'b0001, 4'b0001};
    tbl[13] = '{4'b0001, 4'b0001};
    tbl[14] = '{4'b0110, 4'b0010};
    tbl[15] = '{4'b0000, 4'b0000};
    tbl[16] = '{4'b0100, 4'b0100};
    tbl[17] = '{4'b0011, 4'b0001};
    for (int k = 18; k < 26; k++) tbl[k] = '{4'b0000, 4'b0000};

    i_data = '0;
    set_const(0, 1);
    set_const(1, -32768);
    set_ramp(2);
    set_const(3, 32767);

    rst_n = 1'b0;
    i_req = 4'b1111;
    clr_hist();
    @(posedge clk);
    #1;
    chk("reset grant", longint'(o_grant), 0);
    chk("reset valid", longint'(o_valid), 0);
    chk("reset busy", longint'(o_busy), 0);
    @(posedge clk);
    #1;
    i_req = 4'b0000;
    rst_n = 1'b1;

    for (int k = 0; k < 26; k++) cyc(tbl[k].req, tbl[k].exp_grant, $sformatf("row%0d", k));

    // Reset with three vectors in flight: none may emerge afterwards.
    for (int k = 0; k < 3; k++) cyc(4'b0001, 4'b0001, "rst_pre");
    rst_n = 1'b0;
    #1;
    chk("rst_mid valid", longint'(o_valid), 0);
    chk("rst_mid busy", longint'(o_busy), 0);
    chk("rst_mid grant", longint'(o_grant), 0);
    @(posedge clk);
    #1;
    chk("rst_hold valid", longint'(o_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_hist();
    for (int k = 0; k < 8; k++) cyc(4'b0000, 4'b0000, "rst_post");
    cyc(4'b1111, 4'b0001, "rst_ptr");
    for (int k = 0; k < 7; k++) cyc(4'b0000, 4'b0000, "rst_drain");

`ifdef ADDER_TREE_ARBITER_STATS_EN
    rst_n = 1'b0;
    i_req = 4'b0000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_req = 4'b0010;
    repeat (70000) @(posedge clk);
    #1;
    i_req = 4'b0000;
    chk("cnt req0", longint'(o_grant_cnt[15:0]), 0);
    chk("cnt req1", longint'(o_grant_cnt[31:16]), 65535);
    chk("cnt req2", longint'(o_grant_cnt[47:32]), 0);
    chk("cnt req3", longint'(o_grant_cnt[63:48]), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
